// File: rtl/i2s_pkg.sv
// Shared defaults and payload types for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned I2S_SAMPLE_W = 16;
    localparam int unsigned I2S_SLOT_W   = 32;
    localparam int unsigned I2S_BCLK_DIV = 2;

    typedef struct packed {
        logic [I2S_SAMPLE_W-1:0] left;
        logic [I2S_SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_bit_timer.sv
// I2S bit timing: phase and bit counters, registered BCLK/LRCK, per-bit and frame-load strobes.
module i2s_bit_timer #(
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic lrck,
    output logic advance_c,
    output logic load_c
);

    localparam int unsigned PH_W     = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W    = $clog2(2 * SLOT_W);
    localparam int unsigned LAST_BIT = 2 * SLOT_W - 1;

    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  ph_d;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_d;
    logic             bclk_d;
    logic             lrck_d;

    // Outputs are derived from the next counter values so they line up with the counters.
    always_comb begin
        advance_c = (ph == PH_W'(BCLK_DIV - 1));
        load_c    = advance_c && (bit_cnt == BIT_W'(LAST_BIT));
        ph_d      = advance_c ? '0 : ph + PH_W'(1);
        bit_d     = bit_cnt;
        if (advance_c) begin
            bit_d = (bit_cnt == BIT_W'(LAST_BIT)) ? '0 : bit_cnt + BIT_W'(1);
        end
        bclk_d = (ph_d >= PH_W'(BCLK_DIV / 2));
        lrck_d = (bit_d >= BIT_W'(SLOT_W - 1)) && (bit_d <= BIT_W'(LAST_BIT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            ph      <= ph_d;
            bit_cnt <= bit_d;
            bclk    <= bclk_d;
            lrck    <= lrck_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter with valid/ready input and one-deep holding register.
// Optional I2S_TX_UNDERRUN_REPEAT_EN: underrun frames replay the last loaded pair instead of zeros.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = I2S_SAMPLE_W,
    parameter int unsigned SLOT_W   = I2S_SLOT_W,
    parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned WORD_W = 2 * SLOT_W;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    logic              advance_c;
    logic              load_c;
    logic              xfer;
    logic              hold_full;
    logic              ready_d;
    pair_t             hold_q;
    pair_t             hold_d;
    pair_t             in_pair;
    pair_t             load_pair;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] shifter_q;
    logic [WORD_W-1:0] shifter_d;
    logic              sdata_d;
    logic              fs_d;
    logic              ur_d;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    pair_t             last_q;
    pair_t             last_d;
`endif

    // Left MSB at the top of the frame word, right MSB at the top of the second slot.
    function automatic logic [WORD_W-1:0] slot_word(input pair_t p);
        return (WORD_W'(p.left) << (WORD_W - SAMPLE_W)) |
               (WORD_W'(p.right) << (SLOT_W - SAMPLE_W));
    endfunction

    i2s_bit_timer #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (i2s_bclk),
        .lrck      (i2s_lrck),
        .advance_c (advance_c),
        .load_c    (load_c)
    );

    assign hold_full = !sample_ready;

    // Handshake, frame load and serializer next-state.
    always_comb begin
        hold_d    = hold_q;
        ready_d   = sample_ready;
        shifter_d = shifter_q;
        sdata_d   = i2s_sdata;
        fs_d      = 1'b0;
        ur_d      = 1'b0;
        load_pair = '0;
        word      = '0;
        in_pair   = {sample_l, sample_r};
        xfer      = sample_valid && sample_ready;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        last_d    = last_q;
`endif
        if (load_c) begin
            fs_d = 1'b1;
            if (hold_full) begin
                load_pair = hold_q;
                ready_d   = 1'b1;
            end else if (xfer) begin
                load_pair = in_pair;
            end else begin
                ur_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                load_pair = last_q;
`else
                load_pair = '0;
`endif
            end
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last_d = load_pair;
`endif
            // First bit goes out with the load; the shifter keeps the remainder.
            word      = slot_word(load_pair);
            sdata_d   = word[WORD_W-1];
            shifter_d = word << 1;
        end else begin
            if (xfer) begin
                hold_d  = in_pair;
                ready_d = 1'b0;
            end
            if (advance_c) begin
                sdata_d   = shifter_q[WORD_W-1];
                shifter_d = shifter_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            sample_ready <= 1'b1;
            shifter_q    <= '0;
            i2s_sdata    <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last_q       <= '0;
`endif
        end else begin
            hold_q       <= hold_d;
            sample_ready <= ready_d;
            shifter_q    <= shifter_d;
            i2s_sdata    <= sdata_d;
            frame_start  <= fs_d;
            underrun     <= ur_d;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last_q       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int SW    = I2S_SAMPLE_W;
    localparam int SLOT  = I2S_SLOT_W;
    localparam int DIV   = I2S_BCLK_DIV;
    localparam int FRAME = 2 * SLOT * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] sample_l = '0;
    logic [SW-1:0] sample_r = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          i2s_bclk;
    logic          i2s_lrck;
    logic          i2s_sdata;
    logic          frame_start;
    logic          underrun;

    i2s_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position in frame, holding slot, and the pair currently on the wire.
    int             m_pos = 0;
    logic           m_hold_full = 1'b0;
    stereo_sample_t m_hold = '0;
    stereo_sample_t m_cur = '0;
    stereo_sample_t m_last = '0;
    logic           m_fs = 1'b0;
    logic           m_ur = 1'b0;
    logic           m_xfer = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_hold_full = 1'b0; m_hold = '0; m_cur = '0; m_last = '0;
            m_fs = 1'b0; m_ur = 1'b0; m_xfer = 1'b0;
        end else begin
            m_xfer = sample_valid && !m_hold_full;
            m_fs = 1'b0;
            m_ur = 1'b0;
            if (m_pos == FRAME - 1) begin
                m_fs = 1'b1;
                if (m_hold_full) begin
                    m_cur = m_hold; m_hold_full = 1'b0; m_last = m_cur;
                end else if (m_xfer) begin
                    m_cur = {sample_l, sample_r}; m_last = m_cur;
                end else begin
                    m_ur = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                    m_cur = m_last;
`else
                    m_cur = '0;
`endif
                end
            end else if (m_xfer) begin
                m_hold = {sample_l, sample_r};
                m_hold_full = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    end

    // Expected {ready, bclk, lrck, sdata, frame_start, underrun} at the current frame position.
    function automatic logic [5:0] expect_out();
        int   b;
        logic bclk_e, lrck_e, sd_e;
        b      = m_pos / DIV;
        bclk_e = (m_pos % DIV) >= (DIV / 2);
        lrck_e = (b >= SLOT - 1) && (b <= 2 * SLOT - 2);
        if (b < SW)                          sd_e = m_cur.left[SW - 1 - b];
        else if (b >= SLOT && b < SLOT + SW) sd_e = m_cur.right[SW - 1 - (b - SLOT)];
        else                                 sd_e = 1'b0;
        return {!m_hold_full, bclk_e, lrck_e, sd_e, m_fs, m_ur};
    endfunction

    always @(negedge clk) begin
        logic [5:0] act;
        logic [5:0] exp_v;
        act   = {sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun};
        exp_v = expect_out();
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t pos=%0d got=%b expected=%b (ready,bclk,lrck,sdata,fs,ur)",
                     $time, m_pos, act, exp_v);
        end
    end

    // Deserializer: sdata sampled while bclk is high, 64 bits per frame.
    logic [63:0] rx_shift = '0;
    int          rx_bits = 0;
    logic [63:0] rx_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_bits = 0;
        end else if (i2s_bclk) begin
            rx_shift = {rx_shift[62:0], i2s_sdata};
            rx_bits++;
            if (rx_bits == 2 * SLOT) begin
                rx_q.push_back(rx_shift);
                rx_bits = 0;
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic wait_pos(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(posedge clk); #2;
            if (m_pos == p) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_pos timeout pos=%0d expected=%0d", m_pos, p);
        end
    endtask

    task automatic wait_rx(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < FRAME * (n + 2) && !hit; i++) begin
            @(posedge clk); #2;
            if (rx_q.size() >= n) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_rx timeout frames=%0d expected=%0d", rx_q.size(), n);
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        sample_valid = 1'b0;
        #1 check_lit("async_reset_outputs",
                     64'({sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun}),
                     64'(6'b100000));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rx_q.delete();
    endtask

    function automatic logic [63:0] frame_word(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    logic [15:0] base;
    logic [15:0] cnt;
    int          nx;

    initial begin
        // Silent operation after reset release.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rx_q.delete();
        check_lit("reset_outputs",
                  64'({sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun}),
                  64'(6'b100000));
        wait_pos(61);  check_lit("lrck_low_bit30", 64'(i2s_lrck), 64'(1'b0));
        wait_pos(62);  check_lit("lrck_rise_bit31", 64'(i2s_lrck), 64'(1'b1));
                       check_lit("bclk_low_even", 64'(i2s_bclk), 64'(1'b0));
        wait_pos(63);  check_lit("bclk_high_odd", 64'(i2s_bclk), 64'(1'b1));
        wait_pos(124); check_lit("lrck_high_bit62", 64'(i2s_lrck), 64'(1'b1));
        wait_pos(126); check_lit("lrck_fall_bit63", 64'(i2s_lrck), 64'(1'b0));
        wait_pos(0);   check_lit("first_load_underrun", 64'({frame_start, underrun}), 64'(2'b11));
        wait_rx(2);
        check_lit("silent_frame0", rx_q[0], 64'h0);
        check_lit("silent_frame1", rx_q[1], 64'h0);

        // One sample offered before the first load.
        do_reset();
        sample_l = 16'hA5C3; sample_r = 16'h8001; sample_valid = 1'b1;
        @(posedge clk); #2 sample_valid = 1'b0;
        check_lit("held_ready_low", 64'(sample_ready), 64'(1'b0));
        wait_pos(0);
        check_lit("load_no_underrun", 64'({frame_start, underrun, sample_ready}), 64'(3'b101));
        wait_rx(2);
        check_lit("frame2_a5c3_8001", rx_q[1], 64'hA5C3_0000_8001_0000);

        // Continuous valid with an incrementing payload.
        wait_pos(0);
        base = 16'($urandom);
        cnt = base;
        sample_l = cnt; sample_r = ~cnt; sample_valid = 1'b1;
        rx_q.delete();
        nx = 0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(posedge clk); #2;
            if (m_xfer) begin
                nx++;
                cnt = cnt + 16'd1;
                sample_l = cnt; sample_r = ~cnt;
            end
        end
        sample_valid = 1'b0;
        check_lit("one_xfer_per_frame", 64'(nx), 64'(6));
        wait_rx(7);
        for (int k = 1; k <= 6; k++) begin
            check_lit($sformatf("in_order_frame%0d", k), rx_q[k],
                      frame_word(base + 16'(k - 1), ~(base + 16'(k - 1))));
        end

        // Randomized traffic checked by the model.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_l = 16'($urandom);
            sample_r = 16'($urandom);
        end
        sample_valid = 1'b0;

        // Bypass: valid only on the load cycle with the holding register empty.
        repeat (2 * FRAME) @(posedge clk);
        wait_pos(FRAME - 1);
        check_lit("bypass_ready_before", 64'(sample_ready), 64'(1'b1));
        sample_l = 16'h0F0F; sample_r = 16'hF00D; sample_valid = 1'b1;
        @(posedge clk); #2 sample_valid = 1'b0;
        rx_q.delete();
        check_lit("bypass_load", 64'({frame_start, underrun, sample_ready}), 64'(3'b101));
        wait_rx(1);
        check_lit("bypass_frame", rx_q[0], 64'h0F0F_0000_F00D_0000);

        // Reset mid-frame with a sample held: the sample must be discarded.
        wait_pos(0);
        sample_l = 16'h7777; sample_r = 16'h3333; sample_valid = 1'b1;
        @(posedge clk); #2 sample_valid = 1'b0;
        wait_pos(80);
        check_lit("held_before_reset", 64'(sample_ready), 64'(1'b0));
        do_reset();
        wait_rx(2);
        check_lit("discarded_after_reset", rx_q[1], 64'h0);

        // Single sample then starvation.
        do_reset();
        sample_l = 16'h1234; sample_r = 16'h5678; sample_valid = 1'b1;
        @(posedge clk); #2 sample_valid = 1'b0;
        wait_pos(0); check_lit("starve_load1_ur", 64'(underrun), 64'(1'b0));
        wait_pos(0); check_lit("starve_load2_ur", 64'(underrun), 64'(1'b1));
        wait_pos(0); check_lit("starve_load3_ur", 64'(underrun), 64'(1'b1));
        wait_rx(4);
        check_lit("starve_frame1", rx_q[1], 64'h1234_0000_5678_0000);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        check_lit("starve_frame2", rx_q[2], 64'h1234_0000_5678_0000);
        check_lit("starve_frame3", rx_q[3], 64'h1234_0000_5678_0000);
`else
        check_lit("starve_frame2", rx_q[2], 64'h0);
        check_lit("starve_frame3", rx_q[3], 64'h0);
`endif

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
